// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: op/state codes and decode helpers for the mul/div sequencer
package muldiv_seq_pkg;
    localparam int MD_WIDTH = 32;
    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic [1:0] {
        MD_ST_IDLE,
        MD_ST_RUN,
        MD_ST_FIX
    } md_st_e;
    function automatic logic md_is_arith(input logic [2:0] op);
        return op <= 3'(MD_OP_DIVU);
    endfunction
    function automatic logic md_is_signed(input logic [2:0] op);
        return op == 3'(MD_OP_MULT) || op == 3'(MD_OP_DIV);
    endfunction
    function automatic logic md_is_div(input logic [2:0] op);
        return op == 3'(MD_OP_DIV) || op == 3'(MD_OP_DIVU);
    endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the EX stage and the mul/div sequencer
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave(input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_seq_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring shift-subtract divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH:0]   acc_o,
    output logic               qbit_o
);
    logic [WIDTH:0] sum, rem_s, diff;
    logic           borrow;
    always_comb begin
        sum = acc_i[2*WIDTH:WIDTH] + {1'b0, acc_i[0] ? opnd_i : '0};
        rem_s = acc_i[2*WIDTH-1:WIDTH-1];
        {borrow, diff} = {1'b0, rem_s} - {2'b0, opnd_i};
        acc_o = div_i ? {borrow ? rem_s : diff, acc_i[WIDTH-2:0], 1'b0}
                      : {1'b0, sum, acc_i[WIDTH-1:1]};
        qbit_o = div_i & ~borrow;
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    muldiv_seq_if.slave md
);
    localparam int CW = $clog2(WIDTH);
    md_st_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH:0]   acc_q, acc_d, acc_s;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, hi_d, lo_d, ua, ub, quo, rem;
    logic [2*WIDTH-1:0] prod;
    logic               div_q, neg_q, rneg_q, dz_q, done_q, qbit, sa, sb;
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .opnd_i(opnd_q),
        .acc_o (acc_s),
        .qbit_o(qbit)
    );
    always_comb begin
        sa = md_is_signed(md.op) & md.a[WIDTH-1];
        sb = md_is_signed(md.op) & md.b[WIDTH-1];
        ua = sa ? -md.a : md.a;
        ub = sb ? -md.b : md.b;
        acc_d = {acc_s[2*WIDTH:1], acc_s[0] | qbit};
        prod = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        lo_d = div_q ? (dz_q ? '1 : quo) : prod[WIDTH-1:0];
        hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    end
    // Divide by zero needs no special path for HI: the restoring loop leaves |a| as remainder
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md.flush) begin
                state_q <= MD_ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    MD_ST_IDLE: begin
                        if (md.start && md_is_arith(md.op)) begin
                            acc_q   <= {{(WIDTH+1){1'b0}}, md_is_div(md.op) ? ua : ub};
                            opnd_q  <= md_is_div(md.op) ? ub : ua;
                            div_q   <= md_is_div(md.op);
                            neg_q   <= sa ^ sb;
                            rneg_q  <= sa;
                            dz_q    <= md.b == '0;
                            cnt_q   <= '0;
                            state_q <= MD_ST_RUN;
                        end else if (md.start && md.op == 3'(MD_OP_MTHI)) begin
                            hi_q <= md.a;
                        end else if (md.start && md.op == 3'(MD_OP_MTLO)) begin
                            lo_q <= md.a;
                        end
                    end
                    MD_ST_RUN: begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH-1)) state_q <= MD_ST_FIX;
                    end
                    MD_ST_FIX: begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        done_q  <= 1'b1;
                        state_q <= MD_ST_IDLE;
                    end
                    default: state_q <= MD_ST_IDLE;
                endcase
            end
        end
    end
    assign md.busy = state_q != MD_ST_IDLE;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for the mul/div sequencer
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    res_t        sb[$];
    muldiv_seq_if #(.WIDTH(32)) md ();
    muldiv_seq #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .md   (md)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int intr_at, input int flush_at);
        int   dn = 0;
        int   dlat = 0;
        int   bn = 0;
        res_t r;
        md.op = op;
        md.a = a;
        md.b = b;
        md.start = 1'b1;
        if (flush_at == 0) sb.push_back({eh, el});
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            md.start = (c == intr_at);
            md.flush = (c == flush_at);
            if (c == intr_at) begin
                md.op = MD_OP_MULTU;
                md.a = 32'd9;
                md.b = 32'd9;
            end
            if (md.done) begin
                dn++;
                dlat = c;
            end
            if (md.busy) bn++;
        end
        md.start = 1'b0;
        md.flush = 1'b0;
        if (flush_at == 0) begin
            chk({tag, " latency"}, 64'(dlat), 64'(34));
            chk({tag, " busy_cycles"}, 64'(bn), 64'(33));
            chk({tag, " done_pulses"}, 64'(dn), 64'(1));
            if (sb.size() > 0) begin
                r = sb.pop_front();
                chk({tag, " hi"}, 64'(md.hi), 64'(r.hi));
                chk({tag, " lo"}, 64'(md.lo), 64'(r.lo));
                m_hi = r.hi;
                m_lo = r.lo;
            end
        end else begin
            chk({tag, " done_pulses"}, 64'(dn), 64'(0));
            chk({tag, " busy_cycles"}, 64'(bn), 64'(flush_at));
            chk({tag, " hi_kept"}, 64'(md.hi), 64'(m_hi));
            chk({tag, " lo_kept"}, 64'(md.lo), 64'(m_lo));
        end
    endtask
    initial begin
        md.start = 1'b0;
        md.flush = 1'b0;
        md.op = '0;
        md.a = '0;
        md.b = '0;
        #7;
        chk("rst busy", 64'(md.busy), 64'(0));
        chk("rst done", 64'(md.done), 64'(0));
        chk("rst hi", 64'(md.hi), 64'(0));
        chk("rst lo", 64'(md.lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("multu_7x6", MD_OP_MULTU, 32'd7, 32'd6, 32'h0, 32'd42, 0, 0);
        run("mult_m7x6", MD_OP_MULT, -32'sd7, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 0);
        run("multu_max", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 0, 0);
        run("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
        run("div_m7_2", MD_OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run("div_min_m1", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, 0);
        run("div_5_0", MD_OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 0);
        run("div_m9_0", MD_OP_DIV, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 0, 0);
        run("divu_m1_0", MD_OP_DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run("mult_3x4_restart", MD_OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 5, 0);
        run("div_flush_run", MD_OP_DIV, 32'd50, 32'd5, 32'h0, 32'h0, 0, 10);
        run("mult_flush_fix", MD_OP_MULT, 32'd5, 32'd5, 32'h0, 32'h0, 0, 33);
        md.op = MD_OP_MTLO;
        md.a = 32'h1234;
        md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        m_lo = 32'h1234;
        chk("mtlo lo", 64'(md.lo), 64'(m_lo));
        chk("mtlo busy", 64'(md.busy), 64'(0));
        chk("mtlo done", 64'(md.done), 64'(0));
        md.op = MD_OP_MTHI;
        md.a = 32'hABCD;
        md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        m_hi = 32'hABCD;
        chk("mthi hi", 64'(md.hi), 64'(m_hi));
        chk("mthi lo", 64'(md.lo), 64'(m_lo));
        md.op = 3'd6;
        md.a = 32'hDEAD;
        md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        chk("badop busy", 64'(md.busy), 64'(0));
        chk("badop hi", 64'(md.hi), 64'(m_hi));
        chk("badop lo", 64'(md.lo), 64'(m_lo));
        md.op = MD_OP_MULTU;
        md.a = 32'd1;
        md.b = 32'd1;
        md.start = 1'b1;
        md.flush = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        md.flush = 1'b0;
        chk("flush_beats_start busy", 64'(md.busy), 64'(0));
        md.op = MD_OP_MTLO;
        md.a = 32'h5555;
        md.start = 1'b1;
        md.flush = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        md.flush = 1'b0;
        chk("flush_beats_mtlo lo", 64'(md.lo), 64'(m_lo));
        md.op = MD_OP_MULTU;
        md.a = 32'd7;
        md.b = 32'd6;
        md.start = 1'b1;
        @(negedge clk);
        md.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrun busy", 64'(md.busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst busy", 64'(md.busy), 64'(0));
        chk("async_rst done", 64'(md.done), 64'(0));
        chk("async_rst hi", 64'(md.hi), 64'(0));
        chk("async_rst lo", 64'(md.lo), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
